// File: rtl/sobel_frame_ctrl.sv
// Frame-level sequencer for the sobel pipeline: admits one frame of pixels at a time
// from the host FIFO and waits for the whole frame to reach the output FIFO before the next.
module sobel_frame_ctrl #(
    parameter int IMG_WIDTH     = 720,
    parameter int IMG_HEIGHT    = 540,
    parameter int DRAIN_TIMEOUT = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] num_frames,
    output logic        in_rd_en,
    input  logic [7:0]  in_dout,
    input  logic        in_empty,
    output logic        out_wr_en,
    output logic [7:0]  out_din,
    input  logic        out_full,
    input  logic        mon_wr_en,
    output logic        busy,
    output logic        frame_start,
    output logic        frame_done,
    output logic        run_done,
    output logic [15:0] frame_count,
    output logic        error
);
    localparam int FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW        = $clog2(FRAME_PIX + 1);
    localparam logic [CW-1:0] FRAME_PIX_C  = CW'(FRAME_PIX);
    localparam logic [CW-1:0] LAST_PIX_C   = CW'(FRAME_PIX - 1);
    localparam logic [16:0]   TIMEOUT_LAST = 17'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADMIT, S_DRAIN, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] pix_cnt, pix_cnt_nxt;
    logic [CW-1:0] mon_cnt, mon_cnt_nxt;
    logic [16:0]   idle_cnt, idle_cnt_nxt;
    logic [15:0]   frames_lat, frames_lat_nxt;
    logic [15:0]   frame_count_nxt;
    logic          error_nxt;
    logic          xfer, mon_live, mon_ovf, frame_complete, timeout;

    // A byte moves whenever the FWFT host FIFO shows data and the padding FIFO has room;
    // read and write strobes are the same combinational signal, so a byte is never held here.
    always_comb begin
        xfer     = (state == S_ADMIT) && !in_empty && !out_full && !abort;
        mon_live = mon_wr_en && ((state == S_ADMIT) || (state == S_DRAIN));
        mon_ovf  = mon_live && (mon_cnt == FRAME_PIX_C);
        frame_complete = (state == S_DRAIN) && !mon_ovf &&
            (({1'b0, mon_cnt} + {{CW{1'b0}}, mon_wr_en}) == {1'b0, FRAME_PIX_C});
        timeout  = (state == S_DRAIN) && !mon_wr_en && (idle_cnt == TIMEOUT_LAST);
    end

    assign in_rd_en  = xfer;
    assign out_wr_en = xfer;
    assign out_din   = xfer ? in_dout : 8'h00;
    assign busy      = (state == S_ADMIT) || (state == S_DRAIN);

    always_comb begin
        state_nxt       = state;
        pix_cnt_nxt     = pix_cnt;
        mon_cnt_nxt     = mon_cnt;
        idle_cnt_nxt    = idle_cnt;
        frames_lat_nxt  = frames_lat;
        frame_count_nxt = frame_count;
        error_nxt       = error;
        frame_start     = 1'b0;
        frame_done      = 1'b0;
        run_done        = 1'b0;

        if (xfer) pix_cnt_nxt = pix_cnt + CW'(1);
        if (mon_live && !mon_ovf) mon_cnt_nxt = mon_cnt + CW'(1);

        if (abort) begin
            state_nxt    = S_IDLE;
            pix_cnt_nxt  = '0;
            mon_cnt_nxt  = '0;
            idle_cnt_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        frames_lat_nxt  = num_frames;
                        frame_count_nxt = '0;
                        error_nxt       = 1'b0;
                        pix_cnt_nxt     = '0;
                        mon_cnt_nxt     = '0;
                        idle_cnt_nxt    = '0;
                        state_nxt       = (num_frames == 16'd0) ? S_DONE : S_ADMIT;
                    end
                end
                S_ADMIT: begin
                    frame_start = xfer && (pix_cnt == '0);
                    if (mon_ovf) begin
                        error_nxt = 1'b1;
                        state_nxt = S_DONE;
                    end else if (xfer && (pix_cnt == LAST_PIX_C)) begin
                        state_nxt = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (mon_ovf) begin
                        error_nxt = 1'b1;
                        state_nxt = S_DONE;
                    end else if (frame_complete) begin
                        frame_done      = 1'b1;
                        frame_count_nxt = frame_count + 16'd1;
                        pix_cnt_nxt     = '0;
                        mon_cnt_nxt     = '0;
                        idle_cnt_nxt    = '0;
                        state_nxt = ((frame_count + 16'd1) == frames_lat) ? S_DONE : S_ADMIT;
                    end else if (mon_wr_en) begin
                        idle_cnt_nxt = '0;
                    end else if (timeout) begin
                        error_nxt = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        idle_cnt_nxt = idle_cnt + 17'd1;
                    end
                end
                S_DONE: begin
                    run_done  = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pix_cnt     <= '0;
            mon_cnt     <= '0;
            idle_cnt    <= '0;
            frames_lat  <= '0;
            frame_count <= '0;
            error       <= 1'b0;
        end else begin
            state       <= state_nxt;
            pix_cnt     <= pix_cnt_nxt;
            mon_cnt     <= mon_cnt_nxt;
            idle_cnt    <= idle_cnt_nxt;
            frames_lat  <= frames_lat_nxt;
            frame_count <= frame_count_nxt;
            error       <= error_nxt;
        end
    end
endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
Frame-level sequencer for the sobel pipeline. Sits between the host pixel FIFO and the padding stage's input FIFO.
- Admits exactly one frame of pixels at a time.
- Waits for the pipeline's output FIFO to receive the full frame before admitting the next frame.
- Provides start/abort control, frame status pulses and a drain timeout error.

Parameters:
IMG_WIDTH, 720, pixels per line of unpadded image
IMG_HEIGHT, 540, lines per frame
DRAIN_TIMEOUT, 65535, max cycles in DRAIN with no mon_wr_en before error
Derived: FRAME_PIX = IMG_WIDTH*IMG_HEIGHT; CW = $clog2(FRAME_PIX+1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  pulse; begins a run when IDLE, ignored otherwise
abort  in  1  synchronous; returns to IDLE from any state
num_frames  in  16  frames per run, sampled on accepted start
in_rd_en  out  1  read strobe to host FIFO (first-word-fall-through)
in_dout  in  8  host FIFO data
in_empty  in  1  host FIFO empty
out_wr_en  out  1  write strobe to padding input FIFO
out_din  out  8  pixel to padding input FIFO
out_full  in  1  padding input FIFO full
mon_wr_en  in  1  copy of the sobel output FIFO write strobe
busy  out  1  high in ADMIT/DRAIN
frame_start  out  1  one-cycle pulse on first admitted pixel of each frame
frame_done  out  1  one-cycle pulse when a frame is fully drained
run_done  out  1  one-cycle pulse at end of run
frame_count  out  16  frames completed in current run
error  out  1  sticky; cleared only by accepted start or reset

Behaviour:
- Reset: state IDLE; all counters 0; every output 0, including out_din.
- States: IDLE, ADMIT, DRAIN, DONE.
- Transfer (ADMIT only): xfer = !in_empty && !out_full. in_rd_en = out_wr_en = xfer, combinational. out_din = in_dout. Zero latency. No transfer in any other state.
- Counters:
  - pix_cnt (CW bits) increments on xfer.
  - mon_cnt (CW bits) increments on mon_wr_en in ADMIT or DRAIN.
  - idle_cnt (17 bits) counts DRAIN cycles since last mon_wr_en; reset on mon_wr_en.
- IDLE:
  - start with num_frames != 0: clear frame_count, error, pix_cnt, mon_cnt; go to ADMIT.
  - start with num_frames == 0: go directly to DONE.
- ADMIT:
  - frame_start is high on the first xfer of a frame (pix_cnt==0 && xfer).
  - On the xfer that makes pix_cnt == FRAME_PIX, go to DRAIN.
- DRAIN:
  - When mon_cnt == FRAME_PIX: pulse frame_done, increment frame_count, clear pix_cnt, mon_cnt and idle_cnt.
  - If the new frame_count == num_frames, go to DONE; otherwise go to ADMIT.
  - mon_wr_en in the same cycle as the completing count is included in mon_cnt (the comparison uses mon_cnt + mon_wr_en).
- DONE: run_done high for one cycle; go to IDLE.
- Error conditions:
  - mon_wr_en while mon_cnt == FRAME_PIX (overflow): set error, go to DONE.
  - idle_cnt reaching DRAIN_TIMEOUT: set error, go to DONE.
  - frame_done is not pulsed on an error exit.
- abort has priority over all transitions. In the abort cycle, xfer is forced to 0 and no pulses are issued. Next state is IDLE; counters clear; frame_count and error are held.
- start in any state other than IDLE is ignored.
- mon_wr_en in IDLE or DONE is ignored.
- num_frames is latched and is not re-read mid-run.

Test Plan:
Use IMG_WIDTH=4, IMG_HEIGHT=3 (FRAME_PIX=12) and DRAIN_TIMEOUT=20 unless stated.
1. Single frame: start, num_frames=1, host FIFO holds 12 bytes 0x01..0x0C, mon_wr_en pulses 12 times after the pixels → out_din sequence 0x01..0x0C with 12 out_wr_en; frame_start on the first; frame_done then run_done; frame_count=1; error=0.
2. Backpressure: out_full toggles every other cycle and in_empty held high for 5 cycles mid-frame → no out_wr_en while full/empty; no lost or duplicated byte; exactly 12 writes.
3. Two frames: num_frames=2, 24 bytes in host FIFO, pixels 13..24 already present → no read of pixel 13 until the first frame_done; then the second frame is admitted; frame_count=2; one run_done.
4. Drain timeout: 12 pixels admitted, only 11 mon_wr_en → error=1 exactly 20 cycles after the last mon_wr_en; run_done; no frame_done.
5. Abort: abort asserted after 6 pixels → in_rd_en low that cycle; state IDLE; busy=0; a new start restarts with pix_cnt=0.
6. Reset mid-DRAIN and num_frames=0: async reset → all outputs 0 immediately; then start with num_frames=0 → run_done one cycle later; no in_rd_en.
